fmul_share_ctrl: RTL and testbench
==================================

FMUL_SHARE_CTRL -- requirements
Module: fmul_share_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum cycles to wait for mul_valid after issue (range 2..255).
REQ-002 Port: clk  in  1  sole clock, rising-edge.
REQ-003 Port: rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 Ports: req0_valid/req1_valid  in  1  requester has an operand pair.
REQ-005 Ports: req0_ready/req1_ready  out  1  operand pair accepted this cycle.
REQ-006 Ports: req0_a, req0_b, req1_a, req1_b  in  32  IEEE-754 single operands.
REQ-007 Ports: rsp0_valid/rsp1_valid  out  1  response available.
REQ-008 Ports: rsp0_ready/rsp1_ready  in  1  requester consumes response.
REQ-009 Ports: rsp0_result/rsp1_result  out  32  product; rsp0_err/rsp1_err  out  1  timeout flag.
REQ-010 Ports: mul_a, mul_b  out  32  operands to the shared multiplier.
REQ-011 Port: mul_start  out  1  one-cycle pulse starting a multiply.
REQ-012 Ports: mul_result  in  32, mul_valid  in  1  multiplier product and completion flag.

Function
REQ-013 The block SHALL serialize two requesters onto one multiplier, one operation in flight at a time.
REQ-014 FSM states: IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE: if any reqN_valid, grant one port, assert that reqN_ready only (combinational), latch a/b, go ISSUE.
REQ-016 Arbitration: round-robin; single request wins; both valid -> port other than last_grant wins.
REQ-017 last_grant SHALL update only on response handshake; reset value 1, so port 0 wins the first tie.
REQ-018 reqN_ready SHALL be 0 in ISSUE, WAIT, RESP.
REQ-019 ISSUE: mul_start=1 for exactly one cycle; next state WAIT; timeout counter cleared.
REQ-020 mul_a/mul_b SHALL hold latched operands stable from ISSUE through RESP.
REQ-021 WAIT: counter increments each cycle; mul_valid=1 -> capture mul_result, err=0, go RESP.
REQ-022 WAIT: counter reaching TIMEOUT_CYCLES with mul_valid=0 -> result 32'h7FC00000, err=1, go RESP.
REQ-023 mul_valid SHALL be ignored in IDLE, ISSUE and RESP; mul_valid on the timeout cycle takes priority (err=0).
REQ-024 RESP: rspN_valid=1 for the granted port only; result/err held stable until rspN_ready=1.
REQ-025 RESP with rspN_ready=1 -> IDLE next cycle; no new grant occurs in that same cycle.
REQ-026 Latency: req handshake cycle T, mul_start T+1, rsp_valid one cycle after the capturing mul_valid cycle.
REQ-027 Non-granted rspN_valid SHALL be 0 at all times; rsp_ready on a non-granted port is ignored.

Reset
REQ-028 On rst=0, immediately: state IDLE, last_grant=1, counter=0, all outputs 0 (mul_a, mul_b, results, errs, valids, readys, mul_start).
REQ-029 Reset mid-operation SHALL discard the in-flight operation with no response; a later mul_valid is ignored.
REQ-030 Deassertion SHALL be followed by normal operation from the first clk edge.

Structure
REQ-031 Shared package fmul_ctrl_pkg SHALL hold the state enum, FMUL_QNAN constant 32'h7FC00000, and default TIMEOUT_CYCLES.
REQ-032 One sub-module, fmul_rr_arb2 (2-way round-robin grant from valid and last_grant, combinational), SHALL be instantiated.
REQ-033 Counter width SHALL be 8 bits.

Verification
REQ-034 Stub multiplier latency 3; req0 1.0*1.0 (3F800000,3F800000) -> mul_start one cycle, rsp0_result 3F800000, err 0.
REQ-035 req0 2.0*2.0 and req1 3.0*3.0 same cycle -> rsp0 40800000 first, then rsp1 41100000.
REQ-036 Both requesters continuously valid for 4 ops -> grants alternate 0,1,0,1.
REQ-037 Stub never asserts mul_valid -> after TIMEOUT_CYCLES in WAIT, rsp err=1, result 7FC00000; next request serviced normally.
REQ-038 rsp0_ready held 0 for 5 cycles -> rsp0_valid/result stable, req1_ready stays 0 until handshake.
REQ-039 rst=0 asserted during WAIT -> all outputs 0 immediately; late mul_valid produces no rsp_valid.

Source files
------------

// File: rtl/fmul_ctrl_pkg.sv
// Shared types and constants for the shared floating-point multiplier controller.
package fmul_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [31:0] FMUL_QNAN              = 32'h7FC0_0000;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/fmul_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the port
// that was not granted last.
module fmul_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fmul_share_ctrl.sv
// Serializes two requesters onto one shared multiplier, one operation in
// flight, with a bounded wait that answers NaN plus an error flag.
module fmul_share_ctrl
  import fmul_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp1_result,
  output logic        rsp0_err,
  output logic        rsp1_err,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  input  logic [31:0] mul_result,
  input  logic        mul_valid
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        last_grant;
  logic        cur_port;
  logic [7:0]  cnt;
  logic [31:0] result;
  logic        err;
  logic [1:0]  grant;
  logic        accept;
  logic        rsp_hs;

  fmul_rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is qualified by rst so nothing is handed out while reset is held.
  assign accept     = (state == IDLE) && rst;
  assign req0_ready = accept & grant[0];
  assign req1_ready = accept & grant[1];

  assign rsp_hs      = cur_port ? rsp1_ready : rsp0_ready;
  assign rsp0_result = result;
  assign rsp1_result = result;
  assign rsp0_err    = err;
  assign rsp1_err    = err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      cnt        <= 8'd0;
      result     <= 32'd0;
      err        <= 1'b0;
      mul_a      <= 32'd0;
      mul_b      <= 32'd0;
      mul_start  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            cur_port  <= grant[1];
            mul_a     <= grant[1] ? req1_a : req0_a;
            mul_b     <= grant[1] ? req1_b : req0_b;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // A completion on the last allowed cycle still wins over the timeout.
          if (mul_valid || cnt == CNT_LAST) begin
            result     <= mul_valid ? mul_result : FMUL_QNAN;
            err        <= !mul_valid;
            rsp0_valid <= !cur_port;
            rsp1_valid <= cur_port;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last_grant <= cur_port;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Directed and random checks of the shared multiplier controller against a
// round-robin scoreboard and a fixed-latency stub multiplier.
module tb_fmul_share_ctrl;
  import fmul_ctrl_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_err, rsp1_err;
  logic [31:0] mul_a, mul_b;
  logic        mul_start;
  logic [31:0] mul_result = '0;
  logic        mul_valid = 1'b0;

  int   n_assert = 0;
  int   n_fail = 0;
  logic model_last = 1'b1;
  logic stub_en = 1'b1;
  int   lat = 0;

  fmul_share_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_result(mul_result), .mul_valid(mul_valid)
  );

  always #5 clk = ~clk;

  // Stub multiplier: known float pairs give true products, others a hash.
  function automatic logic [31:0] stub_prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (a == 32'h40400000 && b == 32'h40400000) return 32'h41100000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h0000_1234;
  endfunction

  // Completion arrives three cycles after the start cycle, regardless of rst.
  always @(posedge clk) begin
    mul_valid <= 1'b0;
    if (mul_start) lat <= 2;
    else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        mul_valid  <= stub_en;
        mul_result <= stub_prod(mul_a, mul_b);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                    rsp0_err, rsp1_err, mul_start}), 32'd0);
    checkOutput({tag, "_mul_a"}, mul_a, 32'd0);
    checkOutput({tag, "_mul_b"}, mul_b, 32'd0);
    checkOutput({tag, "_rsp0_result"}, rsp0_result, 32'd0);
    checkOutput({tag, "_rsp1_result"}, rsp1_result, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
    #1;
  endtask

  // One full transaction from request to response handshake, checked against
  // the round-robin model. Called at negedge+1 with the controller idle.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input int hold, input string tag,
                               output logic port, output logic [31:0] res);
    logic [31:0] ea, eb, er;
    int k;
    port = (v0 && v1) ? ~model_last : v1;
    ea = port ? a1 : a0;
    eb = port ? b1 : b0;
    er = stub_en ? stub_prod(ea, eb) : FMUL_QNAN;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    checkOutput({tag, "_ready_win"}, 32'(port ? req1_ready : req0_ready), 32'd1);
    checkOutput({tag, "_ready_lose"}, 32'(port ? req0_ready : req1_ready), 32'd0);
    @(negedge clk);
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    checkOutput({tag, "_start"}, 32'(mul_start), 32'd1);
    checkOutput({tag, "_mul_a"}, mul_a, ea);
    checkOutput({tag, "_mul_b"}, mul_b, eb);
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
      if (k == 1) checkOutput({tag, "_start_pulse"}, 32'(mul_start), 32'd0);
    end while (!(rsp0_valid || rsp1_valid) && k < TMO + 10);
    checkOutput({tag, "_latency"}, 32'(k), stub_en ? 32'd4 : 32'(TMO + 1));
    checkOutput({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), port ? 32'd2 : 32'd1);
    checkOutput({tag, "_result"}, port ? rsp1_result : rsp0_result, er);
    checkOutput({tag, "_err"}, 32'(port ? rsp1_err : rsp0_err), 32'(!stub_en));
    checkOutput({tag, "_mul_hold"}, {mul_a ^ mul_b}, ea ^ eb);
    checkOutput({tag, "_resp_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    res = port ? rsp1_result : rsp0_result;
    for (int h = 0; h < hold; h++) begin
      rsp0_ready = port; rsp1_ready = !port;
      @(negedge clk); #1;
      checkOutput({tag, "_hold_valid"}, 32'({rsp1_valid, rsp0_valid}), port ? 32'd2 : 32'd1);
      checkOutput({tag, "_hold_result"}, port ? rsp1_result : rsp0_result, er);
      checkOutput({tag, "_hold_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    end
    rsp0_ready = !port; rsp1_ready = port;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    checkOutput({tag, "_rsp_done"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    model_last = port;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        p;
    logic [31:0] r;
    logic        v0, v1;
    $display("[TB] start");
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #1;
    checkAllZero("reset");
    doReset();

    // Single 1.0*1.0 on port 0
    applyStimulus(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, '0, '0, 0, "one", p, r);
    checkOutput("one_port", 32'(p), 32'd0);
    checkOutput("one_value", r, 32'h3F800000);

    // Simultaneous requests after reset: port 0 first
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h40000000, 32'h40000000, 32'h40400000, 32'h40400000, 0, "tie0", p, r);
    checkOutput("tie0_port", 32'(p), 32'd0);
    checkOutput("tie0_value", r, 32'h40800000);
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h40400000, 32'h40400000, 0, "tie1", p, r);
    checkOutput("tie1_port", 32'(p), 32'd1);
    checkOutput("tie1_value", r, 32'h41100000);

    // Continuous contention alternates
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 0, "alt", p, r);
      checkOutput($sformatf("alt%0d_port", i), 32'(p), 32'(i % 2));
    end

    // Timeout then recovery
    stub_en = 1'b0;
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h40000000, 32'h40000000, 0, "tmo", p, r);
    checkOutput("tmo_value", r, 32'h7FC00000);
    stub_en = 1'b1;
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h40400000, 32'h40400000, 0, "after_tmo", p, r);
    checkOutput("after_tmo_value", r, 32'h41100000);

    // Back-pressure with the other port waiting
    applyStimulus(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, $urandom, $urandom, 5, "bp", p, r);
    checkOutput("bp_port", 32'(p), 32'd0);
    applyStimulus(1'b0, 1'b1, '0, '0, $urandom, $urandom, 0, "bp_next", p, r);

    // Random traffic
    for (int i = 0; i < 12; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      stub_en = ($urandom_range(0, 4) != 0);
      applyStimulus(v0, v1, $urandom, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), p, r);
    end
    stub_en = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during WAIT discards the operation
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("midrst_quiet%0d", i), 32'({rsp1_valid, rsp0_valid, mul_start}), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 32'h40000000, 32'h40000000, $urandom, $urandom, 1, "post_rst", p, r);
    checkOutput("post_rst_port", 32'(p), 32'd0);
    checkOutput("post_rst_value", r, 32'h40800000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
